// File: rtl/sink_mc.sv
// rtl/sink_mc.sv - multi-channel FIFO capture sink with channel-by-channel replay to memory
// Optional capture-stall timeout enabled by defining SINK_MC_TIMEOUT_EN.
module sink_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_CH     = 2,
`ifdef SINK_MC_TIMEOUT_EN
  parameter int TIMEOUT    = 1024,
`endif
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH:0]          depth_i,
  input  logic [NUM_CH-1:0]            empty_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            rd_en_o,
  output logic                         mem_we_o,
  output logic [CHW-1:0]               mem_ch_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_data_o,
  output logic                         busy_o,
`ifdef SINK_MC_TIMEOUT_EN
  output logic                         timeout_o,
`endif
  output logic                         done_o
);

  localparam logic [ADDR_WIDTH:0] DMAX = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH:0]    depth_q, depth_d;
  logic [ADDR_WIDTH:0]    wcnt_q [NUM_CH];
  logic [ADDR_WIDTH-1:0]  widx_q [NUM_CH];
  logic [NUM_CH-1:0]      pend_q;
  logic [CHW-1:0]         rch_q;
  logic [ADDR_WIDTH:0]    ridx_q;
  logic                   mem_we_q, done_q;
  logic [CHW-1:0]         mem_ch_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_data_q;
  logic [DATA_WIDTH-1:0]  buf_q [NUM_CH][1 << ADDR_WIDTH];
  logic                   cap_done, idx_last, ch_last;

`ifdef SINK_MC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]          tcnt_q;
  logic                   timeout_q;
  logic [ADDR_WIDTH:0]    wmin;
`endif

  always_comb begin
    depth_d  = (depth_i > DMAX) ? DMAX : depth_i;
    cap_done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_en_o[c] = (state_q == CAPTURE) && !empty_i[c] && (wcnt_q[c] < depth_q);
      if (wcnt_q[c] != depth_q) cap_done = 1'b0;
    end
    idx_last = (ridx_q == depth_q - 1'b1);
    ch_last  = (rch_q == CHW'(NUM_CH - 1));
`ifdef SINK_MC_TIMEOUT_EN
    wmin = wcnt_q[0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (wcnt_q[c] < wmin) wmin = wcnt_q[c];
    end
`endif
  end

  // The final delayed write lands on the same edge that enters DRAIN, so the first read sees it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      pend_q     <= '0;
      rch_q      <= '0;
      ridx_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_ch_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        wcnt_q[c] <= '0;
        widx_q[c] <= '0;
      end
`ifdef SINK_MC_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      pend_q   <= rd_en_o;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_en_o[c]) begin
          wcnt_q[c] <= wcnt_q[c] + 1'b1;
          widx_q[c] <= wcnt_q[c][ADDR_WIDTH-1:0];
        end
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            depth_q <= depth_d;
            rch_q   <= '0;
            ridx_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= '0;
`ifdef SINK_MC_TIMEOUT_EN
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
            state_q <= (depth_d == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_done) begin
            state_q <= DRAIN;
          end
`ifdef SINK_MC_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT)) begin
            timeout_q <= 1'b1;
            depth_q   <= wmin;
            state_q   <= (wmin == '0) ? DONE : DRAIN;
          end
          if (|rd_en_o) tcnt_q <= '0;
          else          tcnt_q <= tcnt_q + 1'b1;
`endif
        end
        DRAIN: begin
          mem_we_q   <= 1'b1;
          mem_ch_q   <= rch_q;
          mem_addr_q <= ridx_q[ADDR_WIDTH-1:0];
          mem_data_q <= buf_q[rch_q][ridx_q[ADDR_WIDTH-1:0]];
          if (idx_last) begin
            ridx_q <= '0;
            rch_q  <= rch_q + 1'b1;
            if (ch_last) state_q <= DONE;
          end else begin
            ridx_q <= ridx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_q[c]) buf_q[c][widx_q[c]] <= data_i[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_ch_o   = mem_ch_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign done_o     = done_q;
  // Busy covers the done pulse cycle so it drops only after completion is signalled.
  assign busy_o     = (state_q != IDLE) || done_q;
`ifdef SINK_MC_TIMEOUT_EN
  assign timeout_o  = timeout_q;
`endif

endmodule

// File: doc/sink_mc.md
Name: sink_mc

Overview:
- Multi-channel simulation/capture sink; successor to the single-channel FIFO sink.
- Drains NUM_CH independent FIFOs in parallel into per-channel local buffers, each up to a programmable depth.
- Then replays all captured words channel by channel into the output memory port, and pulses done.
- Sits at the tail of the interpolator datapath, feeding the result memory read by the testbench/host.

Parameters:
DATA_WIDTH, 32, word width of every channel and the output memory.
ADDR_WIDTH, 7, log2 of per-channel buffer depth (128 words).
NUM_CH, 2, number of input FIFO channels (1..8).

Ports:
clk  in  1  clock.
rstn  in  1  reset, asynchronous, active-low.
start_i  in  1  start pulse; sampled only in IDLE.
depth_i  in  ADDR_WIDTH+1  words to capture per channel; latched at start.
empty_i  in  NUM_CH  per-channel FIFO empty flag.
data_i  in  NUM_CH*DATA_WIDTH  per-channel FIFO read data; channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
rd_en_o  out  NUM_CH  per-channel FIFO read strobe.
mem_we_o  out  1  output memory write enable.
mem_ch_o  out  max(1,$clog2(NUM_CH))  channel of current write.
mem_addr_o  out  ADDR_WIDTH  word index within channel.
mem_data_o  out  DATA_WIDTH  write data.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0; buffer contents undefined.
- States: IDLE, CAPTURE, DRAIN, DONE; 2-bit registered state.
- IDLE:
  - start_i=1 latches depth; values > 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH.
  - Latched depth 0 goes directly to DONE.
  - Otherwise goes to CAPTURE.
- CAPTURE, per channel c:
  - rd_en_o[c] = !empty_i[c] && wcnt[c] < depth (combinational).
  - FIFO read latency is 1 cycle: data_i[c] is written to buf[c][wptr_d[c]] on the cycle after rd_en_o[c].
  - wcnt[c] increments on each rd_en_o[c].
  - Channels progress independently; empty on one channel never stalls another.
  - Go to DRAIN when every wcnt equals depth and the last delayed write has landed (one cycle after the final rd_en).
- DRAIN:
  - Read pointer (ch, idx) starts at (0,0); idx increments every cycle.
  - idx wraps to 0 and ch increments at idx = depth-1.
  - Buffer read is synchronous. mem_we_o, mem_ch_o, mem_addr_o and mem_data_o are registered together and appear one cycle after the read issues; the four are always aligned.
  - Exactly NUM_CH*depth write beats, contiguous, no bubbles.
  - Go to DONE on the cycle the final beat is presented.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o is 0 in IDLE only.
- start_i in any state other than IDLE is ignored.
- Reset mid-operation aborts immediately to IDLE with counters cleared; no further rd_en_o or mem_we_o.
- Counters are ADDR_WIDTH+1 bits, so depth = 2^ADDR_WIDTH works without overflow.

Optional Feature:
- Macro: SINK_MC_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 1024) and output timeout_o.
  - In CAPTURE, a cycle counter clears on any rd_en_o and otherwise increments.
  - When it reaches TIMEOUT, the block moves to DRAIN with the per-channel depth reduced to min(wcnt) across channels.
  - timeout_o is set sticky until the next accepted start_i.
  - done_o still pulses.
- When undefined: no counter, no port; CAPTURE waits indefinitely.

Test Plan:
- NUM_CH=2, depth=4, both FIFOs preloaded (ch0 0x10..0x13, ch1 0x20..0x23), start pulse:
  - rd_en_o=2'b11 for 4 cycles.
  - 8 contiguous writes (ch,addr,data) = (0,0,0x10)..(0,3,0x13),(1,0,0x20)..(1,3,0x23).
  - done_o 1 cycle after the last write; busy_o low the cycle after that.
- ch1 empty_i toggled high every other cycle, depth=3: ch0 finishes in 3 cycles; ch1 rd_en_o only when empty_i=0; DRAIN waits for ch1; write data is still correct.
- depth_i=0 with start: no rd_en_o, no mem_we_o, done_o exactly 2 cycles after start.
- depth_i=200 with ADDR_WIDTH=7: clamps to 128; 256 writes; mem_addr_o wraps 127->0 as mem_ch_o goes 0->1.
- rstn pulsed low mid-DRAIN after 5 beats: outputs 0 immediately. A new start with depth=2 then yields exactly 4 correct writes.
- SINK_MC_TIMEOUT_EN, TIMEOUT=16, ch1 stays empty after 2 words, depth=5: timeout_o rises; 2 beats per channel drained (4 total); done_o pulses.
